// File: rtl/ddr4_dll_code_tracker.sv
// Power-up, lock acquisition and periodic code refresh for the DDR4 DLL.
// Accepted codes are rate-limited and passed to the lane delay lines over a req/ack handshake.
module ddr4_dll_code_tracker #(
    parameter int PWRDN_CYCLES     = 16,
    parameter int LOCK_TIMEOUT     = 4096,
    parameter int UPDATE_INTERVAL  = 1024,
    parameter int SETTLE_CYCLES    = 8,
    parameter int MAX_STEP         = 4,
    parameter int LOCK_LOSS_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       ARST_N,
    input  logic       DLL_LOCK,
    input  logic [7:0] DLL_CODE,
    input  logic       DLL_DELAY_DIFF,
    output logic       DLL_POWERDOWN_N,
    output logic       DLL_CODE_UPDATE,
    output logic [7:0] CODE_OUT,
    output logic       CODE_REQ,
    input  logic       CODE_ACK,
    output logic       LOCKED,
    output logic       LOCK_LOST,
    output logic       DELAY_DIFF_SYNC,
    output logic [3:0] RETRY_CNT
);

    localparam int CW = 16;
    localparam logic signed [8:0] STEP = 9'(MAX_STEP);

    typedef enum logic [2:0] {
        S_PWRDN, S_WAIT_LOCK, S_UPDATE, S_SETTLE, S_SAMPLE, S_LOAD, S_IDLE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    loss_cnt_q;
    logic          lock_meta_q, lock_s_q, dd_meta_q, dd_s_q;
    logic          first_q, phase_q;
    logic [1:0]    attempt_q;
    logic [7:0]    cap_q, code_q, code_d;
    logic          pwrdn_n_q, upd_q, req_q, locked_q, lost_q;
    logic [3:0]    retry_q;
    logic          tracking, loss_now;
    logic signed [8:0] diff_s;

    assign tracking = (state_q == S_UPDATE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE) ||
                      (state_q == S_LOAD) || (state_q == S_IDLE);
    assign loss_now = tracking && !lock_s_q && (loss_cnt_q == 8'(LOCK_LOSS_CYCLES - 1));

    // Clamp the stable sample to within MAX_STEP of the current code; 9-bit signed avoids wrap.
    assign diff_s = $signed({1'b0, cap_q}) - $signed({1'b0, code_q});
    always_comb begin
        code_d = cap_q;
        if (diff_s > STEP) begin
            code_d = code_q + 8'(MAX_STEP);
        end else if (diff_s < -STEP) begin
            code_d = code_q - 8'(MAX_STEP);
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q     <= S_PWRDN;
            cnt_q       <= '0;
            loss_cnt_q  <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            dd_meta_q   <= 1'b0;
            dd_s_q      <= 1'b0;
            first_q     <= 1'b1;
            phase_q     <= 1'b0;
            attempt_q   <= '0;
            cap_q       <= '0;
            code_q      <= '0;
            pwrdn_n_q   <= 1'b0;
            upd_q       <= 1'b0;
            req_q       <= 1'b0;
            locked_q    <= 1'b0;
            lost_q      <= 1'b0;
            retry_q     <= '0;
        end else begin
            lock_meta_q <= DLL_LOCK;
            lock_s_q    <= lock_meta_q;
            dd_meta_q   <= DLL_DELAY_DIFF;
            dd_s_q      <= dd_meta_q;

            if (!tracking || lock_s_q) begin
                loss_cnt_q <= '0;
            end else begin
                loss_cnt_q <= loss_cnt_q + 8'd1;
            end

            // Loss of lock overrides every tracking-state action, including a pending ack.
            if (loss_now) begin
                state_q   <= S_PWRDN;
                cnt_q     <= '0;
                lost_q    <= 1'b1;
                locked_q  <= 1'b0;
                first_q   <= 1'b1;
                req_q     <= 1'b0;
                upd_q     <= 1'b0;
                pwrdn_n_q <= 1'b0;
            end else begin
                case (state_q)
                    S_PWRDN: begin
                        if (cnt_q == CW'(PWRDN_CYCLES - 1)) begin
                            state_q   <= S_WAIT_LOCK;
                            cnt_q     <= '0;
                            pwrdn_n_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (lock_s_q) begin
                            state_q  <= S_UPDATE;
                            cnt_q    <= '0;
                            upd_q    <= 1'b1;
                            locked_q <= 1'b1;
                        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                            state_q   <= S_PWRDN;
                            cnt_q     <= '0;
                            pwrdn_n_q <= 1'b0;
                            if (retry_q != 4'hF) begin
                                retry_q <= retry_q + 4'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_UPDATE: begin
                        state_q <= S_SETTLE;
                        cnt_q   <= '0;
                        upd_q   <= 1'b0;
                    end
                    S_SETTLE: begin
                        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                            state_q   <= S_SAMPLE;
                            cnt_q     <= '0;
                            phase_q   <= 1'b0;
                            attempt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        if (!phase_q) begin
                            cap_q   <= DLL_CODE;
                            phase_q <= 1'b1;
                        end else if (DLL_CODE == cap_q) begin
                            phase_q <= 1'b0;
                            if (first_q || (code_d != code_q)) begin
                                code_q  <= first_q ? cap_q : code_d;
                                first_q <= 1'b0;
                                req_q   <= 1'b1;
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_IDLE;
                                cnt_q   <= '0;
                            end
                        end else begin
                            phase_q <= 1'b0;
                            if (attempt_q == 2'd2) begin
                                state_q <= S_IDLE;
                                cnt_q   <= '0;
                            end else begin
                                attempt_q <= attempt_q + 2'd1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (CODE_ACK) begin
                            req_q   <= 1'b0;
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    S_IDLE: begin
                        if (cnt_q == CW'(UPDATE_INTERVAL - 1)) begin
                            state_q <= S_UPDATE;
                            cnt_q   <= '0;
                            upd_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_PWRDN;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign DLL_POWERDOWN_N = pwrdn_n_q;
    assign DLL_CODE_UPDATE = upd_q;
    assign CODE_OUT        = code_q;
    assign CODE_REQ        = req_q;
    assign LOCKED          = locked_q;
    assign LOCK_LOST       = lost_q;
    assign DELAY_DIFF_SYNC = dd_s_q;
    assign RETRY_CNT       = retry_q;

endmodule
